mc_sync_fifo: RTL and testbench

- Multi-channel, single-clock FIFO built on one shared dual-port array, partitioned into CHANNELS independent queues of DEPTH = 2**ADDRESS_BITS words each.
- Owns the per-channel pointers, full/empty/almost-full flags, registered read data and error pulses internally; callers no longer drive addresses.
- Used as the next-generation buffer wherever several logical streams share one clock domain.

---
 rtl/mc_sync_fifo.sv | 123 ++++++++++++
 tb/tb_mc_sync_fifo.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mc_sync_fifo.sv
// Multi-channel synchronous FIFO: CHANNELS independent queues share one dual-port array.
// Each channel owns its pointers and flags. Read data is registered with one clock of latency.
module mc_sync_fifo #(
    parameter int DSIZE        = 8,
    parameter int ADDRESS_BITS = 4,
    parameter int CHANNELS     = 4,
    parameter int AFULL_LEVEL  = (1 << ADDRESS_BITS) - 2,
    localparam int CHAN_BITS   = $clog2(CHANNELS)
) (
    input  logic                 wclk,
    input  logic                 wrst,
    input  logic                 winc,
    input  logic [CHAN_BITS-1:0] wchan,
    input  logic [DSIZE-1:0]     wdata,
    input  logic                 rinc,
    input  logic [CHAN_BITS-1:0] rchan,
    output logic [DSIZE-1:0]     rdata,
    output logic                 rvalid,
    output logic [CHANNELS-1:0]  wfull,
    output logic [CHANNELS-1:0]  rempty,
    output logic [CHANNELS-1:0]  afull,
    output logic                 werr,
    output logic                 rerr
);
    localparam int DEPTH = 1 << ADDRESS_BITS;
    localparam int PW    = ADDRESS_BITS + 1;
    localparam int AW    = CHAN_BITS + ADDRESS_BITS;

    logic [DSIZE-1:0] mem [CHANNELS*DEPTH];

    logic [CHANNELS-1:0]                   wr_acc;
    logic [CHANNELS-1:0]                   rd_acc;
    logic [CHANNELS-1:0][ADDRESS_BITS-1:0] wlow;
    logic [CHANNELS-1:0][ADDRESS_BITS-1:0] rlow;
    logic [AW-1:0]                         waddr;
    logic [AW-1:0]                         raddr;
    logic                                  wr_en;
    logic                                  rd_en;

    logic [DSIZE-1:0] rdata_reg;
    logic             rvalid_reg;
    logic             werr_reg;
    logic             rerr_reg;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic [PW-1:0] wptr_reg;
            logic [PW-1:0] rptr_reg;
            logic [PW-1:0] count;

            // Wrap bit makes the modular difference span 0..DEPTH unambiguously.
            assign count       = wptr_reg - rptr_reg;
            assign wfull[gi]   = (count == PW'(DEPTH));
            assign rempty[gi]  = (count == '0);
            assign afull[gi]   = (count >= PW'(AFULL_LEVEL));
            assign wlow[gi]    = wptr_reg[ADDRESS_BITS-1:0];
            assign rlow[gi]    = rptr_reg[ADDRESS_BITS-1:0];

            // An out-of-range channel select matches no decode, so it is rejected.
            assign wr_acc[gi]  = winc && (wchan == CHAN_BITS'(gi)) && !wfull[gi];
            assign rd_acc[gi]  = rinc && (rchan == CHAN_BITS'(gi)) && !rempty[gi];

            always_ff @(posedge wclk) begin
                if (wrst) begin
                    wptr_reg <= '0;
                    rptr_reg <= '0;
                end else begin
                    if (wr_acc[gi]) begin
                        wptr_reg <= wptr_reg + 1'b1;
                    end
                    if (rd_acc[gi]) begin
                        rptr_reg <= rptr_reg + 1'b1;
                    end
                end
            end
        end
    endgenerate

    assign wr_en = (|wr_acc) && !wrst;
    assign rd_en = (|rd_acc) && !wrst;

    always_comb begin
        waddr = '0;
        raddr = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (wr_acc[c]) begin
                waddr = {CHAN_BITS'(c), wlow[c]};
            end
            if (rd_acc[c]) begin
                raddr = {CHAN_BITS'(c), rlow[c]};
            end
        end
    end

    always_ff @(posedge wclk) begin
        if (wr_en) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            rdata_reg  <= '0;
            rvalid_reg <= 1'b0;
            werr_reg   <= 1'b0;
            rerr_reg   <= 1'b0;
        end else begin
            rvalid_reg <= rd_en;
            werr_reg   <= winc && !(|wr_acc);
            rerr_reg   <= rinc && !(|rd_acc);
            if (rd_en) begin
                rdata_reg <= mem[raddr];
            end
        end
    end

    assign rdata  = rdata_reg;
    assign rvalid = rvalid_reg;
    assign werr   = werr_reg;
    assign rerr   = rerr_reg;

endmodule

// File: tb/tb_mc_sync_fifo.sv
// Scoreboard bench for mc_sync_fifo: stimulus queues expected responses, a negedge monitor pops
// and compares them, and the stimulus checks the per-channel flags after each cycle.
module tb_mc_sync_fifo;
    logic       wclk = 1'b0;
    logic       wrst;
    logic       winc;
    logic [1:0] wchan;
    logic [7:0] wdata;
    logic       rinc;
    logic [1:0] rchan;
    logic [7:0] rdata;
    logic       rvalid;
    logic [3:0] wfull;
    logic [3:0] rempty;
    logic [3:0] afull;
    logic       werr;
    logic       rerr;

    mc_sync_fifo #(
        .DSIZE(8),
        .ADDRESS_BITS(2),
        .CHANNELS(4),
        .AFULL_LEVEL(3)
    ) dut (
        .wclk(wclk),
        .wrst(wrst),
        .winc(winc),
        .wchan(wchan),
        .wdata(wdata),
        .rinc(rinc),
        .rchan(rchan),
        .rdata(rdata),
        .rvalid(rvalid),
        .wfull(wfull),
        .rempty(rempty),
        .afull(afull),
        .werr(werr),
        .rerr(rerr)
    );

    always #5 wclk = ~wclk;

    typedef struct {
        int tag;
        bit rst;
        bit werr;
        bit rerr;
        bit rvalid;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] rd_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;

    always @(posedge wclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: one expectation record per driven cycle, read data popped whenever rvalid shows.
    exp_t       mon_e;
    logic [7:0] mon_d;
    logic [7:0] held = 8'h00;
    always @(negedge wclk) begin
        if (exp_q.size() > 0 && exp_q[0].tag < cyc) begin
            mon_e = exp_q.pop_front();
            chk("werr", {31'd0, werr}, {31'd0, mon_e.werr});
            chk("rerr", {31'd0, rerr}, {31'd0, mon_e.rerr});
            chk("rvalid", {31'd0, rvalid}, {31'd0, mon_e.rvalid});
            if (mon_e.rst) held = 8'h00;
            if (rvalid) begin
                if (rd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rdata_unexpected: got rvalid with rdata %0h, expected no read", rdata);
                end else begin
                    mon_d = rd_q.pop_front();
                    chk("rdata", {24'd0, rdata}, {24'd0, mon_d});
                    held = mon_d;
                end
            end else begin
                chk("rdata_hold", {24'd0, rdata}, {24'd0, held});
            end
        end
    end

    task automatic step(input bit rst, input bit w, input logic [1:0] wc, input logic [7:0] wd,
                        input bit r, input logic [1:0] rc,
                        input bit ew, input bit er, input bit ev, input logic [7:0] ed);
        exp_t e;
        wrst  = rst;
        winc  = w;
        wchan = wc;
        wdata = wd;
        rinc  = r;
        rchan = rc;
        e.tag = cyc;
        e.rst = rst;
        e.werr = ew;
        e.rerr = er;
        e.rvalid = ev;
        exp_q.push_back(e);
        if (ev) rd_q.push_back(ed);
        $display("txn cyc=%0d rst=%0b w=%0b wc=%0d wd=%02h r=%0b rc=%0d exp_werr=%0b exp_rerr=%0b exp_rd=%0b/%02h",
                 cyc, rst, w, wc, wd, r, rc, ew, er, ev, ed);
        @(posedge wclk);
        #1;
        wrst = 1'b0;
        winc = 1'b0;
        rinc = 1'b0;
    endtask

    task automatic wr(input logic [1:0] c, input logic [7:0] d, input bit ew);
        step(1'b0, 1'b1, c, d, 1'b0, 2'd0, ew, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic rd(input logic [1:0] c, input bit ok, input logic [7:0] d);
        step(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, c, 1'b0, !ok, ok, d);
    endtask

    task automatic flags(input string tag, input logic [3:0] e, input logic [3:0] f, input logic [3:0] a);
        chk({tag, "_rempty"}, {28'd0, rempty}, {28'd0, e});
        chk({tag, "_wfull"}, {28'd0, wfull}, {28'd0, f});
        chk({tag, "_afull"}, {28'd0, afull}, {28'd0, a});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        wrst  = 1'b1;
        winc  = 1'b0;
        wchan = 2'd0;
        wdata = 8'h00;
        rinc  = 1'b0;
        rchan = 2'd0;
        @(posedge wclk);
        #1;

        // Reset for two cycles
        step(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00);
        flags("reset", 4'b1111, 4'b0000, 4'b0000);

        // Fill ch1 past full, then drain past empty
        wr(2'd1, 8'h11, 1'b0); flags("fill1", 4'b1101, 4'b0000, 4'b0000);
        wr(2'd1, 8'h22, 1'b0); flags("fill2", 4'b1101, 4'b0000, 4'b0000);
        wr(2'd1, 8'h33, 1'b0); flags("fill3", 4'b1101, 4'b0000, 4'b0010);
        wr(2'd1, 8'h44, 1'b0); flags("fill4", 4'b1101, 4'b0010, 4'b0010);
        wr(2'd1, 8'h55, 1'b1); flags("fill5", 4'b1101, 4'b0010, 4'b0010);
        rd(2'd1, 1'b1, 8'h11); flags("drain1", 4'b1101, 4'b0000, 4'b0010);
        rd(2'd1, 1'b1, 8'h22); flags("drain2", 4'b1101, 4'b0000, 4'b0000);
        rd(2'd1, 1'b1, 8'h33);
        rd(2'd1, 1'b1, 8'h44); flags("drain4", 4'b1111, 4'b0000, 4'b0000);
        rd(2'd1, 1'b0, 8'h00); flags("drain5", 4'b1111, 4'b0000, 4'b0000);

        // Channel isolation
        wr(2'd0, 8'hA0, 1'b0);
        wr(2'd3, 8'hB3, 1'b0); flags("iso_w", 4'b0110, 4'b0000, 4'b0000);
        rd(2'd3, 1'b1, 8'hB3);
        rd(2'd0, 1'b1, 8'hA0); flags("iso_r", 4'b1111, 4'b0000, 4'b0000);

        // Simultaneous same-channel access on ch2: empty, steady, full
        step(1'b0, 1'b1, 2'd2, 8'hC1, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 8'h00);
        flags("sim_empty", 4'b1011, 4'b0000, 4'b0000);
        step(1'b0, 1'b1, 2'd2, 8'hC2, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 8'hC1);
        flags("sim_mid", 4'b1011, 4'b0000, 4'b0000);
        wr(2'd2, 8'hC3, 1'b0);
        wr(2'd2, 8'hC4, 1'b0);
        wr(2'd2, 8'hC5, 1'b0); flags("sim_fill", 4'b1011, 4'b0100, 4'b0100);
        step(1'b0, 1'b1, 2'd2, 8'hC6, 1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 8'hC2);
        flags("sim_full", 4'b1011, 4'b0000, 4'b0100);
        rd(2'd2, 1'b1, 8'hC3);
        rd(2'd2, 1'b1, 8'hC4);
        rd(2'd2, 1'b1, 8'hC5); flags("sim_drain", 4'b1111, 4'b0000, 4'b0000);

        // Pointer wrap on ch0
        for (int i = 0; i < 10; i++) begin
            wr(2'd0, 8'(i), 1'b0); flags("wrap_w", 4'b1110, 4'b0000, 4'b0000);
            rd(2'd0, 1'b1, 8'(i)); flags("wrap_r", 4'b1111, 4'b0000, 4'b0000);
        end

        // Reset while ch1 holds 3 words and a read is requested
        wr(2'd1, 8'hD1, 1'b0);
        wr(2'd1, 8'hD2, 1'b0);
        wr(2'd1, 8'hD3, 1'b0); flags("mid_fill", 4'b1101, 4'b0000, 4'b0010);
        step(1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 8'h00);
        flags("mid_rst", 4'b1111, 4'b0000, 4'b0000);
        rd(2'd1, 1'b0, 8'h00);

        step(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00);
        @(negedge wclk);
        #1;
        chk("exp_q_drained", exp_q.size(), 32'd0);
        chk("rd_q_drained", rd_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
